bgd_mul_fixp_pipe: RTL and testbench
====================================

// Module: bgd_mul_fixp_pipe
// PURPOSE
//  Parametrised pipelined signed fixed-point multiplier for the BGD datapath; next generation
//  of the fixed 12x12 DSP48 multiplier. Adds independent operand/result widths, configurable
//  depth, binary-point shift with optional rounding/saturation, overflow flag and valid/ready
//  flow control so it can sit between streaming stages without external delay matching.
// PARAMETERS
//  A_W        12  signed width of operand a
//  B_W        12  signed width of operand b
//  P_W        12  signed width of result p
//  FRAC_SHIFT 0   arithmetic right shift applied to full product (0..A_W+B_W-1)
//  ROUND      0   0: truncate toward -inf; 1: round half up (add 2^(FRAC_SHIFT-1) before shift)
//  SAT        0   0: wrap to low P_W bits; 1: saturate to P_W signed range
//  NUM_STAGE  4   pipeline latency in cycles, legal 3..8
// PORTS
//  clk        in   1    clock, all logic on rising edge
//  reset_n    in   1    asynchronous active-low reset
//  ce         in   1    clock enable; 0 freezes entire block
//  in_valid   in   1    a/b valid
//  in_ready   out  1    block accepts a/b this cycle
//  a          in   A_W  signed operand
//  b          in   B_W  signed operand
//  out_valid  out  1    p/ovf valid
//  out_ready  in   1    downstream accepts p this cycle
//  p          out  P_W  signed result
//  ovf        out  1    result clamped (SAT=1) or wrapped (SAT=0)
// BEHAVIOUR
//  - One clock, clk. reset_n asynchronous, active-low; deassertion synchronous to clk.
//  - Reset: all stage valid bits, data regs, p, ovf, out_valid = 0. In-flight data discarded.
//  - adv = ce & (~out_valid | out_ready); in_ready = adv (combinational). Accept = in_valid & in_ready.
//  - When adv=1 every stage shifts one step (valid bit + data); when adv=0 all regs hold.
//  - Stage 1: register a, b. Stage 2: full product a*b, width A_W+B_W, exact.
//  - Stages 3..NUM_STAGE-1: delay regs. Last stage: round/shift/limit, registers p, ovf, out_valid.
//  - Latency: accepted at edge k appears on p with out_valid=1 after edge k+NUM_STAGE-1 when no stall
//    (i.e. NUM_STAGE cycles from input presentation to output). Throughput 1/cycle.
//  - Arithmetic: r = (full + (ROUND && FRAC_SHIFT>0 ? 2^(FRAC_SHIFT-1) : 0)) >>> FRAC_SHIFT,
//    rounding add carried at A_W+B_W+1 bits (no internal overflow).
//  - SAT=1: p = clamp(r, -2^(P_W-1), 2^(P_W-1)-1); ovf=1 iff clamped.
//  - SAT=0: p = r[P_W-1:0]; ovf=1 iff sign-extension of p != r.
//  - Bubbles: invalid stages shift as bubbles; no collapse. out_valid=0 slots carry don't-care p.
//  - Stall: out_valid=1 & out_ready=0 -> p, ovf, out_valid held stable, in_ready=0, no data lost.
//  - Simultaneous out_ready and in_valid at full pipe: output retires and input accepted same edge.
//  - ce=0: no accept, no retire, outputs stable, in_ready=0 regardless of out_ready.
//  - Defaults (12/12/12, shift 0, wrap, 4 stages) give results bit-identical to legacy multiplier.
// TESTING
//  1 Defaults, a=-5 b=7, out_ready=1 -> p=12'hFDD (-35), ovf=0, out_valid exactly 4 cycles after present.
//  2 Defaults, a=100 b=30 -> p=-1096 (12'hBB8), ovf=1; SAT=1 same -> p=2047 ovf=1;
//    SAT=1 a=-2048 b=2047 -> p=-2048 ovf=1.
//  3 FRAC_SHIFT=4: a=25 b=3 -> ROUND=0 p=4, ROUND=1 p=5; a=-25 b=3 -> ROUND=0 p=-5, ROUND=1 p=-5;
//    a=-24 b=3 -> ROUND=1 p=-4, ovf=0 throughout.
//  4 8 back-to-back inputs a=i b=i+1, out_ready=0 on cycles 6..9 -> all 8 products in order,
//    none dropped/duplicated, p stable and in_ready=0 while stalled.
//  5 ce=0 for 3 cycles mid-stream -> all outputs frozen, sequence afterwards identical to ce=1 run.
//  6 reset_n low asynchronously (mid-cycle) with 3 in flight -> out_valid=0, p=0 immediately;
//    after release no stale result emitted, next input returns correct p after NUM_STAGE cycles.

Source files
------------

// File: rtl/bgd_mul_fixp_pipe.sv
// Pipelined signed fixed-point multiplier: register operands, exact product, delay stages,
// then binary-point shift with optional rounding and wrap/saturate limiting.
module bgd_mul_fixp_pipe #(
  parameter int A_W        = 12,
  parameter int B_W        = 12,
  parameter int P_W        = 12,
  parameter int FRAC_SHIFT = 0,
  parameter int ROUND      = 0,
  parameter int SAT        = 0,
  parameter int NUM_STAGE  = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           ce,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] p,
  output logic           ovf
);

  localparam int FW     = A_W + B_W;
  localparam int DN     = NUM_STAGE - 2;
  localparam int RW     = FW + 1 + P_W;
  localparam int RND_SH = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
  localparam logic [FW:0] RND =
    (ROUND != 0 && FRAC_SHIFT > 0) ? ((FW + 1)'(1) << RND_SH) : '0;
  localparam logic signed [RW-1:0] P_MAX = {{(RW - P_W + 1){1'b0}}, {(P_W - 1){1'b1}}};
  localparam logic signed [RW-1:0] P_MIN = {{(RW - P_W + 1){1'b1}}, {(P_W - 1){1'b0}}};

  // Handshake: a/b are taken on any edge where in_valid & in_ready; p/ovf retire on any edge
  // where out_valid & out_ready. The whole pipe advances in lock-step (bubbles included), so
  // in_ready is simply "the pipe moves this edge": ce high and the output slot empty or leaving.
  logic adv;
  assign adv      = ce & (~out_valid | out_ready);
  assign in_ready = adv;

  logic signed [A_W-1:0] a_q;
  logic signed [B_W-1:0] b_q;
  logic                  v1_q;
  logic signed [FW-1:0]  prod_q [DN];
  logic [DN-1:0]         pv_q;

  logic signed [FW-1:0] a_x;
  logic signed [FW-1:0] b_x;
  logic signed [FW-1:0] mul;
  assign a_x = {{B_W{a_q[A_W-1]}}, a_q};
  assign b_x = {{A_W{b_q[B_W-1]}}, b_q};
  assign mul = a_x * b_x;

  // Output-stage arithmetic; the rounding add is one bit wider than the product so it cannot wrap.
  logic signed [FW-1:0] full;
  logic signed [FW:0]   sum;
  logic signed [FW:0]   r;
  logic signed [RW-1:0] r_w;
  logic [P_W-1:0]       lo;
  logic signed [RW-1:0] lo_x;
  logic                 wrap_ovf;
  logic [P_W-1:0]       p_nxt;
  logic                 ovf_nxt;

  assign full     = prod_q[DN-1];
  assign sum      = {full[FW-1], full} + RND;
  assign r        = sum >>> FRAC_SHIFT;
  assign r_w      = {{P_W{r[FW]}}, r};
  assign lo       = r_w[P_W-1:0];
  assign lo_x     = {{(RW - P_W){lo[P_W-1]}}, lo};
  assign wrap_ovf = (lo_x != r_w);

  always_comb begin
    p_nxt   = lo;
    ovf_nxt = wrap_ovf;
    if (SAT != 0) begin
      if (r_w > P_MAX) begin
        p_nxt   = P_MAX[P_W-1:0];
        ovf_nxt = 1'b1;
      end else if (r_w < P_MIN) begin
        p_nxt   = P_MIN[P_W-1:0];
        ovf_nxt = 1'b1;
      end else begin
        ovf_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q       <= '0;
      b_q       <= '0;
      v1_q      <= 1'b0;
      pv_q      <= '0;
      for (int i = 0; i < DN; i++) prod_q[i] <= '0;
      p         <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      a_q       <= a;
      b_q       <= b;
      v1_q      <= in_valid;
      prod_q[0] <= mul;
      pv_q[0]   <= v1_q;
      for (int i = 1; i < DN; i++) begin
        prod_q[i] <= prod_q[i-1];
        pv_q[i]   <= pv_q[i-1];
      end
      p         <= p_nxt;
      ovf       <= ovf_nxt;
      out_valid <= pv_q[DN-1];
    end
  end

endmodule

// File: tb/tb_bgd_mul_fixp_pipe.sv
// Directed bench for bgd_mul_fixp_pipe: four parameterisations share one stimulus stream,
// checked with immediate assertions against hand-computed values and an in-order expected queue.
module tb_bgd_mul_fixp_pipe;

  logic        clk;
  logic        reset_n;
  logic        ce;
  logic        in_valid;
  logic        out_ready;
  logic [11:0] a;
  logic [11:0] b;

  logic        ir_d, ir_s, ir_t, ir_r;
  logic        ov_d, ov_s, ov_t, ov_r;
  logic [11:0] p_d, p_s, p_t, p_r;
  logic        f_d, f_s, f_t, f_r;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  // defaults (wrap, no shift)
  bgd_mul_fixp_pipe dut_d (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .in_ready(ir_d),
    .a(a), .b(b), .out_valid(ov_d), .out_ready(out_ready), .p(p_d), .ovf(f_d));

  bgd_mul_fixp_pipe #(.SAT(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .in_ready(ir_s),
    .a(a), .b(b), .out_valid(ov_s), .out_ready(out_ready), .p(p_s), .ovf(f_s));

  bgd_mul_fixp_pipe #(.FRAC_SHIFT(4), .ROUND(0)) dut_t (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .in_ready(ir_t),
    .a(a), .b(b), .out_valid(ov_t), .out_ready(out_ready), .p(p_t), .ovf(f_t));

  bgd_mul_fixp_pipe #(.FRAC_SHIFT(4), .ROUND(1)) dut_r (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .in_ready(ir_r),
    .a(a), .b(b), .out_valid(ov_r), .out_ready(out_ready), .p(p_r), .ovf(f_r));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] h12(input int v);
    return v[11:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; presents one operand pair and checks the 4-cycle latency and all results.
  task automatic single_op(input string tag, input int av, input int bv,
                           input int e_d, input int e_s, input int e_t, input int e_r,
                           input logic o_d, input logic o_s, input logic o_t, input logic o_r);
    a = h12(av);
    b = h12(bv);
    in_valid = 1'b1;
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(ir_d), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("%s.early_valid%0d", tag, c), 32'(ov_d), 32'd0);
      @(posedge clk);
    end
    #1;
    @(negedge clk);
    chk({tag, ".out_valid"}, 32'(ov_d), 32'd1);
    chk({tag, ".p_wrap"}, 32'(p_d), 32'(h12(e_d)));
    chk({tag, ".p_sat"},  32'(p_s), 32'(h12(e_s)));
    chk({tag, ".p_trunc"}, 32'(p_t), 32'(h12(e_t)));
    chk({tag, ".p_round"}, 32'(p_r), 32'(h12(e_r)));
    chk({tag, ".ovf_wrap"}, 32'(f_d), 32'(o_d));
    chk({tag, ".ovf_sat"},  32'(f_s), 32'(o_s));
    chk({tag, ".ovf_trunc"}, 32'(f_t), 32'(o_t));
    chk({tag, ".ovf_round"}, 32'(f_r), 32'(o_r));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    ce = 1'b1;
    out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Eight back-to-back products a=i, b=i+1 with optional out_ready-low and ce-low windows.
  task automatic run_stream(input string tag, input int st_lo, input int st_hi,
                            input int ce_lo, input int ce_hi);
    int idx = 0;
    int retired = 0;
    int cyc = 0;
    logic prev_hold = 1'b0;
    logic prev_ov = 1'b0;
    logic [11:0] prev_p = '0;
    exp_q.delete();
    while (retired < 8 && cyc < 60) begin
      ce        = !(cyc >= ce_lo && cyc <= ce_hi);
      out_ready = !(cyc >= st_lo && cyc <= st_hi);
      in_valid  = (idx < 8);
      a = h12(idx);
      b = h12(idx + 1);
      @(negedge clk);
      if (prev_hold) begin
        chk({tag, ".held_valid"}, 32'(ov_d), 32'(prev_ov));
        chk({tag, ".held_p"}, 32'(p_d), 32'(prev_p));
      end
      if (!ce || (ov_d && !out_ready))
        chk({tag, ".in_ready_blocked"}, 32'(ir_d), 32'd0);
      if (in_valid && ir_d) begin
        exp_q.push_back(h12(idx * (idx + 1)));
        idx++;
      end
      if (ce && ov_d && out_ready) begin
        chk({tag, ".unexpected_out"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk($sformatf("%s.p%0d", tag, retired), 32'(p_d), 32'(exp_q.pop_front()));
        retired++;
      end
      prev_hold = !ce || (ov_d && !out_ready);
      prev_ov   = ov_d;
      prev_p    = p_d;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, ".retired"}, 32'(retired), 32'd8);
    chk({tag, ".accepted"}, 32'(idx), 32'd8);
    chk({tag, ".leftover"}, 32'(exp_q.size()), 32'd0);
    idle(2);
  endtask

  initial begin
    reset_n   = 1'b1;
    ce        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", 32'(ov_d), 32'd0);
    chk("reset.p", 32'(p_d), 32'd0);
    chk("reset.ovf", 32'(f_d), 32'd0);
    chk("reset.p_sat", 32'(p_s), 32'd0);
    reset_n = 1'b1;
    idle(2);

    single_op("neg_small", -5, 7, -35, -35, -3, -2, 1'b0, 1'b0, 1'b0, 1'b0);
    single_op("pos_ovf", 100, 30, -1096, 2047, 187, 188, 1'b1, 1'b1, 1'b0, 1'b0);
    single_op("neg_ovf", -2048, 2047, -2048, -2048, 128, 128, 1'b1, 1'b1, 1'b1, 1'b1);
    single_op("frac_pos", 25, 3, 75, 75, 4, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    single_op("frac_neg", -25, 3, -75, -75, -5, -5, 1'b0, 1'b0, 1'b0, 1'b0);
    single_op("frac_half", -24, 3, -72, -72, -5, -4, 1'b0, 1'b0, 1'b0, 1'b0);

    idle(3);
    run_stream("stall", 6, 9, 100, 99);
    run_stream("ce_off", 100, 99, 3, 5);

    // Fill the pipe with output stalled, then reset asynchronously mid-cycle.
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = h12(3 + i);
      b = 12'd5;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("prereset.out_valid", 32'(ov_d), 32'd1);
    chk("prereset.p", 32'(p_d), 32'd15);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset.out_valid", 32'(ov_d), 32'd0);
    chk("async_reset.p", 32'(p_d), 32'd0);
    chk("async_reset.ovf", 32'(f_d), 32'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("post_reset.stale%0d", i), 32'(ov_d), 32'd0);
    end
    @(posedge clk);
    #1;
    single_op("post_reset", -5, 7, -35, -35, -3, -2, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
